// File: rtl/tcp_tx_route_tagger_if.sv
// Valid/ready metadata stream used on both sides of the TX route tagger.
interface metaIntf #(
  parameter int unsigned WIDTH = 26
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);
endinterface

// File: rtl/tcp_tx_route_tagger.sv
// TCP TX route tagger: looks up the route ID of each TX metadata beat and tags it.
// Optional single-entry route cache, enabled by defining TX_ROUTE_CACHE_EN.
module tcp_tx_route_tagger #(
  parameter int unsigned TCP_SESSION_BITS = 10,
  parameter int unsigned LOOKUP_TIMEOUT   = 8,
  parameter logic [13:0] DEFAULT_ROUTE    = 14'h0000
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  metaIntf.s                          s_tx_meta,
  metaIntf.m                          m_tx_meta,
  output logic [TCP_SESSION_BITS-1:0] tx_sid,
  output logic                        tx_sid_valid,
  input  logic [13:0]                 tx_route_id,
  input  logic                        tx_route_id_valid,
  input  logic                        cache_inv,
  output logic [31:0]                 timeout_cnt
);

  localparam int unsigned SID_W   = TCP_SESSION_BITS;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned ROUTE_W = 14;
  localparam int unsigned TIMER_W = 8;
  localparam int unsigned CNT_W   = 32;

  typedef struct packed {
    logic [SID_W-1:0] sid;
    logic [LEN_W-1:0] len;
  } meta_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SEND   = 2'd3
  } state_t;

  state_t               r_state;
  meta_t                r_meta;
  logic [ROUTE_W-1:0]   r_route;
  logic [TIMER_W-1:0]   r_timer;
  logic [CNT_W-1:0]     r_timeout_cnt;
  logic                 r_s_ready;
  logic                 r_m_valid;
  logic                 r_sid_valid;

  state_t               w_state_nxt;
  meta_t                w_meta_nxt;
  logic [ROUTE_W-1:0]   w_route_nxt;
  logic [TIMER_W-1:0]   w_timer_nxt;
  logic [TIMER_W-1:0]   w_timer_inc;
  logic [CNT_W-1:0]     w_timeout_cnt_nxt;
  logic                 w_fill;
  logic                 w_hit;
  meta_t                w_in;

  assign w_in        = meta_t'(s_tx_meta.data);
  assign w_timer_inc = r_timer + TIMER_W'(1);

  // Next-state and datapath updates; the response beats the timer in the same cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_meta_nxt        = r_meta;
    w_route_nxt       = r_route;
    w_timer_nxt       = r_timer;
    w_timeout_cnt_nxt = r_timeout_cnt;
    w_fill            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_tx_meta.valid) begin
          w_meta_nxt = w_in;
          if (w_hit) begin
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_route_id_valid) begin
          w_route_nxt = tx_route_id;
          w_fill      = 1'b1;
          w_state_nxt = ST_SEND;
        end else begin
          w_timer_nxt = w_timer_inc;
          if (w_timer_inc == TIMER_W'(LOOKUP_TIMEOUT)) begin
            w_route_nxt       = DEFAULT_ROUTE;
            w_timeout_cnt_nxt = (&r_timeout_cnt) ? r_timeout_cnt
                                                 : r_timeout_cnt + CNT_W'(1);
            w_state_nxt       = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (m_tx_meta.ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef TX_ROUTE_CACHE_EN
  logic               r_cache_valid;
  logic [SID_W-1:0]   r_cache_sid;
  logic [ROUTE_W-1:0] r_cache_route;
  logic [ROUTE_W-1:0] w_route_sel;

  assign w_hit       = r_cache_valid && !cache_inv && (w_in.sid == r_cache_sid);
  assign w_route_sel = (r_state == ST_IDLE && s_tx_meta.valid && w_hit) ? r_cache_route
                                                                         : w_route_nxt;

  // Single-entry cache; invalidate wins over a same-cycle fill.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cache_valid <= 1'b0;
      r_cache_sid   <= '0;
      r_cache_route <= '0;
    end else begin
      if (cache_inv) begin
        r_cache_valid <= 1'b0;
      end else if (w_fill) begin
        r_cache_valid <= 1'b1;
      end
      if (w_fill) begin
        r_cache_sid   <= r_meta.sid;
        r_cache_route <= tx_route_id;
      end
    end
  end
`else
  logic               w_unused;
  logic [ROUTE_W-1:0] w_route_sel;

  assign w_hit       = 1'b0;
  assign w_route_sel = w_route_nxt;
  assign w_unused    = ^{cache_inv, w_fill};
`endif

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_meta        <= '0;
      r_route       <= '0;
      r_timer       <= '0;
      r_timeout_cnt <= '0;
      r_s_ready     <= 1'b1;
      r_m_valid     <= 1'b0;
      r_sid_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_meta        <= w_meta_nxt;
      r_route       <= w_route_sel;
      r_timer       <= w_timer_nxt;
      r_timeout_cnt <= w_timeout_cnt_nxt;
      r_s_ready     <= (w_state_nxt == ST_IDLE);
      r_m_valid     <= (w_state_nxt == ST_SEND);
      r_sid_valid   <= (w_state_nxt == ST_LOOKUP);
    end
  end

  assign s_tx_meta.ready = r_s_ready;
  assign m_tx_meta.valid = r_m_valid;
  assign m_tx_meta.data  = {r_route, r_meta};
  assign tx_sid          = r_meta.sid;
  assign tx_sid_valid    = r_sid_valid;
  assign timeout_cnt     = r_timeout_cnt;

endmodule

// File: tb/tb_tcp_tx_route_tagger.sv
// Scoreboard bench for tcp_tx_route_tagger: directed cases followed by random traffic.
`timescale 1ns/1ps
module tb_tcp_tx_route_tagger;

  localparam int unsigned SB  = 10;
  localparam int unsigned TO  = 8;
  localparam logic [13:0] DEF = 14'h2A5C;

  typedef struct {
    logic [SB-1:0] sid;
    logic [15:0]   len;
    bit            hit;
    logic [13:0]   route;
  } exp_t;

  logic          aclk;
  logic          aresetn;
  logic [SB-1:0] tx_sid;
  logic          tx_sid_valid;
  logic [13:0]   rsp_route;
  logic          rsp_valid;
  logic          cache_inv;
  logic [31:0]   timeout_cnt;

  metaIntf #(.WIDTH(SB + 16))      s_if ();
  metaIntf #(.WIDTH(14 + SB + 16)) m_if ();

  tcp_tx_route_tagger #(
    .TCP_SESSION_BITS (SB),
    .LOOKUP_TIMEOUT   (TO),
    .DEFAULT_ROUTE    (DEF)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_tx_meta         (s_if),
    .m_tx_meta         (m_if),
    .tx_sid            (tx_sid),
    .tx_sid_valid      (tx_sid_valid),
    .tx_route_id       (rsp_route),
    .tx_route_id_valid (rsp_valid),
    .cache_inv         (cache_inv),
    .timeout_cnt       (timeout_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // main-owned controls
  int          force_d     = 0;
  logic [13:0] force_route = '0;
  bit          rand_ready  = 0;
  bit          drv_hang    = 0;
  bit          final_req   = 0;

  // monitor-owned responder plan
  int          plan_cyc   = 0;
  int          plan_d     = 0;
  logic [13:0] plan_route = '0;
  bit          plan_set   = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Connection-table model: answers each strobe after the planned delay.
  initial begin
    rsp_valid = 1'b0;
    rsp_route = '0;
    forever begin
      @(posedge aclk);
      #1;
      rsp_valid = plan_set && (cyc == plan_cyc + plan_d);
      rsp_route = rsp_valid ? plan_route : 14'($urandom);
    end
  end

  // Reference model and scoreboard: all sampling on the falling edge.
  initial begin : monitor
    exp_t        q[$];
    logic [13:0] route_q[$];
    exp_t        e;
    logic [13:0] er;
    logic [39:0] hold_data;
    bit          hold_valid = 0, busy = 0, cur_hit = 0, first_seen = 0, final_done = 0;
    bit          c_valid = 0, fill_pend = 0;
    logic [SB-1:0] cur_sid = '0, c_sid = '0, fill_sid = '0;
    logic [13:0] c_route = '0, fill_route = '0, r;
    int          acc_cyc = 0, exp_vcyc = 0, strobes = 0, fill_cyc = 0, rst_cnt = 0, d;
    logic [31:0] exp_to = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        if (rst_cnt > 0) begin
          chk("rst_sid_valid", 64'(tx_sid_valid), 64'(0));
          chk("rst_sid", 64'(tx_sid), 64'(0));
          chk("rst_m_valid", 64'(m_if.valid), 64'(0));
          chk("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
        end
        rst_cnt++;
        q.delete();
        route_q.delete();
        busy = 0; hold_valid = 0; first_seen = 0; strobes = 0;
        c_valid = 0; fill_pend = 0; exp_to = 0;
      end else begin
        rst_cnt = 0;
        chk("s_ready", 64'(s_if.ready), 64'(!busy));
        if (!busy) begin
          chk("idle_m_valid", 64'(m_if.valid), 64'(0));
          chk("idle_timeout_cnt", 64'(timeout_cnt), 64'(exp_to));
        end
        if (tx_sid_valid) begin
          chk("strobe_expected", 64'(busy && !cur_hit && strobes == 0), 64'(1));
          chk("strobe_sid", 64'(tx_sid), 64'(cur_sid));
          chk("strobe_cycle", 64'(cyc), 64'(acc_cyc + 1));
          strobes++;
          d = (force_d != 0) ? force_d : int'($urandom_range(1, TO + 3));
          r = (force_d != 0) ? force_route : 14'($urandom);
          plan_cyc = cyc; plan_d = d; plan_route = r; plan_set = 1;
          if (d <= int'(TO)) begin
            route_q.push_back(r);
            fill_pend = 1; fill_cyc = cyc + d; fill_sid = cur_sid; fill_route = r;
            exp_vcyc = cyc + d + 1;
          end else begin
            route_q.push_back(DEF);
            if (exp_to != '1) exp_to++;
            exp_vcyc = cyc + int'(TO) + 1;
          end
        end
`ifdef TX_ROUTE_CACHE_EN
        if (cache_inv) c_valid = 0;
        if (fill_pend && cyc == fill_cyc) begin
          fill_pend = 0;
          if (!cache_inv) begin
            c_valid = 1; c_sid = fill_sid; c_route = fill_route;
          end
        end
`endif
        if (m_if.valid && busy) begin
          if (!first_seen) begin
            chk("out_latency", 64'(cyc), 64'(exp_vcyc));
            first_seen = 1;
          end
          if (hold_valid) chk("out_stable", 64'(m_if.data), 64'(hold_data));
          if (m_if.ready) begin
            if (q.size() > 0) begin
              e = q.pop_front();
              chk("lookup_strobes", 64'(strobes), 64'(e.hit ? 0 : 1));
              er = e.hit ? e.route : ((route_q.size() > 0) ? route_q.pop_front() : DEF);
              chk("out_data", 64'(m_if.data), 64'({er, e.sid, e.len}));
            end
            busy = 0; hold_valid = 0; first_seen = 0;
          end else begin
            hold_valid = 1;
            hold_data  = m_if.data;
          end
        end
        if (s_if.valid && s_if.ready) begin
          chk("accept_when_idle", 64'(busy), 64'(0));
          e.sid   = s_if.data[SB+15:16];
          e.len   = s_if.data[15:0];
          e.hit   = c_valid && !cache_inv && (c_sid == e.sid);
          e.route = c_route;
          q.push_back(e);
          busy = 1; acc_cyc = cyc; cur_sid = e.sid; cur_hit = e.hit;
          strobes = 0; first_seen = 0; hold_valid = 0;
          if (e.hit) exp_vcyc = cyc + 1;
        end
        if (final_req && !final_done) begin
          chk("final_timeout_cnt", 64'(timeout_cnt), 64'(exp_to));
          chk("final_queue_empty", 64'(q.size()), 64'(0));
          chk("driver_stall", 64'(drv_hang), 64'(0));
          final_done = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_ready) m_if.ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic send_beat(input logic [SB-1:0] sid, input logic [15:0] len, input bit inv);
    int budget = 0;
    bit done = 0;
    s_if.valid = 1'b1;
    s_if.data  = {sid, len};
    cache_inv  = inv;
    while (!done) begin
      @(negedge aclk);
      done = s_if.ready;
      tick();
      budget++;
      if (!done && budget > 300) begin
        drv_hang = 1;
        done     = 1;
      end
    end
    s_if.valid = 1'b0;
    s_if.data  = (SB + 16)'($urandom);
    cache_inv  = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    bit done = 0;
    while (!done) begin
      @(negedge aclk);
      done = s_if.ready;
      tick();
      budget++;
      if (!done && budget > 300) begin
        drv_hang = 1;
        done     = 1;
      end
    end
  endtask

  initial begin
    int budget;
    aresetn     = 1'b0;
    s_if.valid  = 1'b0;
    s_if.data   = '0;
    m_if.ready  = 1'b1;
    cache_inv   = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // basic lookup, one-cycle table response
    force_d = 1; force_route = 14'h1A2B;
    send_beat(10'd5, 16'd64, 0);
    wait_idle();

    // timeout with a late response two cycles after expiry, then same sid again
    force_d = TO + 2; force_route = 14'h1555;
    send_beat(10'd9, 16'h0100, 0);
    wait_idle();
    force_d = 2; force_route = 14'h0777;
    send_beat(10'd9, 16'h0101, 0);
    wait_idle();

    // backpressure: output stalled while a second beat waits
    force_d = 1; force_route = 14'h1111;
    m_if.ready = 1'b0;
    send_beat(10'd11, 16'hAAAA, 0);
    fork
      send_beat(10'd12, 16'hBBBB, 0);
      begin
        repeat (14) tick();
        m_if.ready = 1'b1;
      end
    join
    wait_idle();

    // sids 3,3,7 then invalidate on a cached sid
    force_d = 1; force_route = 14'h0333;
    send_beat(10'd3, 16'd100, 0);
    wait_idle();
    force_route = 14'h0777;
    send_beat(10'd3, 16'd101, 0);
    wait_idle();
    force_route = 14'h0707;
    send_beat(10'd7, 16'd102, 0);
    wait_idle();
    force_route = 14'h0123;
    send_beat(10'd3, 16'd103, 0);
    wait_idle();
    force_route = 14'h0456;
    send_beat(10'd3, 16'd104, 1);
    wait_idle();
    force_route = 14'h0999;
    send_beat(10'd3, 16'd105, 0);
    wait_idle();

    // reset while waiting on the table; its response lands after reset
    force_d = TO + 3; force_route = 14'h3EEE;
    send_beat(10'd20, 16'h2020, 0);
    budget = 0;
    while (!tx_sid_valid && budget < 20) begin
      @(negedge aclk);
      budget++;
    end
    if (!tx_sid_valid) drv_hang = 1;
    tick();
    tick();
    aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    repeat (10) tick();
    force_d = 1; force_route = 14'h0ABC;
    send_beat(10'd20, 16'h2021, 0);
    wait_idle();
    force_route = 14'h0DEF;
    send_beat(10'd3, 16'h2022, 0);
    wait_idle();

    // random traffic
    force_d    = 0;
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_beat(SB'($urandom_range(1, 4)), 16'($urandom), ($urandom_range(0, 15) == 0));
    end
    rand_ready = 0;
    m_if.ready = 1'b1;
    wait_idle();
    repeat (2) tick();

    final_req = 1;
    repeat (3) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
